// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU memory path: the RAM handshake status and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between icache and dcache. Data normally wins, but an
// instruction fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ramerr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       ramerr_q, ramerr_d;
  logic       d_req;

  assign d_req  = dREN | dWEN;
  assign ramerr = ramerr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      ramerr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ramerr_q     <= ramerr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ramerr_d     = ramerr_q | ((state_q != IDLE) && (ramstate == ERROR));
    case (state_q)
      IDLE: begin
        if (iREN && (starve_cnt_q == STARVE_LIM)) begin
          state_d      = IGRANT;
          starve_cnt_d = 4'd0;
        end else if (d_req) begin
          state_d = DGRANT;
          // Only count data grants that actually make a fetch wait.
          if (!iREN) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (iREN) begin
          state_d      = IGRANT;
          starve_cnt_d = 4'd0;
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
      DGRANT: begin
        if (!d_req || (ramstate == ACCESS)) begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN || (ramstate == ACCESS)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes follow the live request lines, so an abort cycle drives no strobe.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = d_req;
    case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (d_req && (ramstate == ACCESS)) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (iREN && (ramstate == ACCESS)) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: completions are matched in order against
// expected {requester, address, load} entries pushed when the stimulus is driven.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      ramerr;

  typedef struct {
    bit    is_i;
    word_t addr;
    word_t load;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   auto_ram = 1'b0;
  int   age      = 0;

  localparam word_t KEY = 32'hA5A5_0000;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  task automatic chk(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Completion monitor: pops the scoreboard on every granted completion.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && iREN && !iwait) begin
      if (exp_q.size() == 0) chk("unexpected_i", 32'(iwait), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("i_order", 32'(e.is_i), 32'd1);
        chk("i_addr", ramaddr, e.addr);
        chk("iload", iload, e.load);
      end
    end
    if (!RST && (dREN || dWEN) && !dwait) begin
      if (exp_q.size() == 0) chk("unexpected_d", 32'(dwait), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("d_order", 32'(e.is_i), 32'd0);
        chk("d_addr", ramaddr, e.addr);
        chk("dload", dload, e.load);
      end
    end
  end

  // Simple RAM model used for back-to-back traffic: one BUSY cycle, then ACCESS.
  always @(posedge CLK) begin
    #1;
    if (auto_ram) begin
      if (ramREN || ramWEN) begin
        if (age == 0) begin
          ramstate = BUSY;
          age = 1;
        end else begin
          ramstate = ACCESS;
          ramload  = ramaddr ^ KEY;
          age = 0;
        end
      end else begin
        ramstate = FREE;
        age = 0;
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramerr", 32'(ramerr), 32'd0);
    step();
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0;

    // Instruction fetch, one BUSY then ACCESS.
    step();
    iREN = 1'b1; iaddr = 32'h40;
    exp_q.push_back('{is_i: 1'b1, addr: 32'h40, load: 32'h1234});
    @(negedge CLK);
    chk("a_idle_ren", 32'(ramREN), 32'd0);
    chk("a_idle_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = BUSY;
    @(negedge CLK);
    chk("a_g1_ren", 32'(ramREN), 32'd1);
    chk("a_g1_wen", 32'(ramWEN), 32'd0);
    chk("a_g1_addr", ramaddr, 32'h40);
    chk("a_g1_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = ACCESS; ramload = 32'h1234;
    @(negedge CLK);
    chk("a_acc_iwait", 32'(iwait), 32'd0);
    step();
    ramstate = FREE;
    @(negedge CLK);
    chk("a_idle2_ren", 32'(ramREN), 32'd0);
    chk("a_idle2_iwait", 32'(iwait), 32'd1);
    chk("a_idle2_iload", iload, 32'd0);
    step();
    iREN = 1'b0;
    @(negedge CLK);
    chk("a_abort_ren", 32'(ramREN), 32'd0);
    step();

    // Data write with both strobes requested: write wins.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD;
    exp_q.push_back('{is_i: 1'b0, addr: 32'h80, load: 32'h5555});
    @(negedge CLK);
    chk("b_idle_wen", 32'(ramWEN), 32'd0);
    chk("b_idle_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = ACCESS; ramload = 32'h5555;
    @(negedge CLK);
    chk("b_wen", 32'(ramWEN), 32'd1);
    chk("b_ren", 32'(ramREN), 32'd0);
    chk("b_store", ramstore, 32'hDEAD);
    chk("b_dwait", 32'(dwait), 32'd0);
    step();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("b_after_wen", 32'(ramWEN), 32'd0);

    // ERROR for three cycles, then ACCESS; ramerr must stick.
    step();
    dREN = 1'b1; daddr = 32'h100;
    @(negedge CLK);
    chk("c_idle_err", 32'(ramerr), 32'd0);
    step();
    ramstate = ERROR;
    @(negedge CLK);
    chk("c_e1_dwait", 32'(dwait), 32'd1);
    chk("c_e1_err", 32'(ramerr), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge CLK);
      chk("c_e_dwait", 32'(dwait), 32'd1);
      chk("c_e_err", 32'(ramerr), 32'd1);
    end
    step();
    ramstate = ACCESS; ramload = 32'h77;
    exp_q.push_back('{is_i: 1'b0, addr: 32'h100, load: 32'h77});
    @(negedge CLK);
    chk("c_acc_dwait", 32'(dwait), 32'd0);
    step();
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("c_sticky", 32'(ramerr), 32'd1);

    // Data read dropped during BUSY aborts without a completion.
    step();
    dREN = 1'b1; daddr = 32'h200;
    @(negedge CLK);
    step();
    ramstate = BUSY;
    @(negedge CLK);
    chk("d_busy_ren", 32'(ramREN), 32'd1);
    step();
    dREN = 1'b0;
    @(negedge CLK);
    chk("d_abort_ren", 32'(ramREN), 32'd0);
    chk("d_abort_dload", dload, 32'd0);
    step();
    dREN = 1'b1; ramstate = ACCESS; ramload = 32'h99;
    @(negedge CLK);
    chk("d_idle_dwait", 32'(dwait), 32'd1);
    chk("d_idle_ren", 32'(ramREN), 32'd0);
    chk("d_idle_dload", dload, 32'd0);
    step();
    exp_q.push_back('{is_i: 1'b0, addr: 32'h200, load: 32'h99});
    @(negedge CLK);
    chk("d_re_dwait", 32'(dwait), 32'd0);
    step();
    dREN = 1'b0; ramstate = FREE;

    // Reset pulsed mid IGRANT.
    step();
    iREN = 1'b1; iaddr = 32'h300;
    @(negedge CLK);
    step();
    ramstate = BUSY;
    #2;
    chk("e_ren", 32'(ramREN), 32'd1);
    RST = 1'b1;
    ramstate = ACCESS;
    #1;
    chk("e_rst_ren", 32'(ramREN), 32'd0);
    chk("e_rst_iwait", 32'(iwait), 32'd1);
    chk("e_rst_iload", iload, 32'd0);
    chk("e_rst_err", 32'(ramerr), 32'd0);
    step();
    RST = 1'b0; iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("e_post_err", 32'(ramerr), 32'd0);

    // Continuous contention with STARVE_MAX=2: expect D, D, I.
    step();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h400; daddr = 32'h500;
    exp_q.push_back('{is_i: 1'b0, addr: 32'h500, load: 32'h500 ^ KEY});
    exp_q.push_back('{is_i: 1'b0, addr: 32'h500, load: 32'h500 ^ KEY});
    exp_q.push_back('{is_i: 1'b1, addr: 32'h400, load: 32'h400 ^ KEY});
    auto_ram = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge CLK);
    #1;
    iREN = 1'b0; dREN = 1'b0;
    chk("f_drained", 32'(exp_q.size()), 32'd0);
    step();
    step();
    auto_ram = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 CLK  in  1  SHALL be the single clock, rising edge.
REQ-003 RST  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 iREN  in  1  SHALL be the icache read request.
REQ-005 iaddr  in  32  SHALL be the icache word address.
REQ-006 dREN, dWEN  in  1 each  SHALL be the dcache read and write requests.
REQ-007 daddr, dstore  in  32 each  SHALL be the dcache address and write data.
REQ-008 iwait, dwait  out  1 each  SHALL be high while the matching request is pending or not granted.
REQ-009 iload, dload  out  32 each  SHALL return read data to icache and dcache.
REQ-010 ramREN, ramWEN  out  1 each  SHALL be the RAM read and write strobes.
REQ-011 ramaddr, ramstore  out  32 each  SHALL be the RAM address and write data.
REQ-012 ramload  in  32  SHALL be the RAM read data.
REQ-013 ramstate  in  ramstate_t  SHALL be the RAM status: FREE, BUSY, ACCESS or ERROR.
REQ-014 ramerr  out  1  SHALL be a sticky flag for any ramstate==ERROR seen during a grant.

Function
REQ-015 FSM states SHALL be IDLE, DGRANT and IGRANT.
REQ-016 In IDLE, all RAM strobes SHALL be 0, and iwait/dwait SHALL be 1 for any asserted request.
REQ-017 In IDLE, the winner SHALL be registered on the next edge: data (dREN|dWEN) beats instruction, except when starve_cnt==STARVE_MAX and iREN=1, in which case instruction wins.
REQ-018 In DGRANT: ramaddr=daddr, ramWEN=dWEN, ramREN=dREN&!dWEN (write wins if both), ramstore=dstore.
REQ-019 In IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-020 In the cycle ramstate==ACCESS, the granted requester's wait SHALL be 0 and its load SHALL equal ramload; the other wait SHALL stay 1.
REQ-021 After ACCESS the FSM SHALL return to IDLE on the next edge, giving a minimum request-to-completion latency of 2 cycles (arbitrate, access).
REQ-022 FREE and BUSY during a grant SHALL hold the grant with wait=1.
REQ-023 ERROR during a grant SHALL hold the grant with wait=1 and set ramerr on the next edge.
REQ-024 If the granted requester deasserts its request(s) before ACCESS, the FSM SHALL abort to IDLE on the next edge, and RAM strobes SHALL be 0 in that cycle.
REQ-025 starve_cnt (4 bits) SHALL increment on each DGRANT entry while iREN=1, clear on IGRANT entry, clear when IDLE sees iREN=0, and saturate at STARVE_MAX.
REQ-026 iload/dload SHALL be 0 when their requester is not completing.
REQ-027 Simultaneous new requests arriving in the completion cycle SHALL be arbitrated only in the following IDLE cycle.

Reset
REQ-028 RST high SHALL immediately force: state IDLE, starve_cnt 0, ramerr 0, all RAM strobes 0, iwait=dwait=1 (if requested), loads 0.
REQ-029 Reset asserted mid-grant SHALL abandon the transaction with no completion pulse.

Structure
REQ-030 ramstate_t and word_t SHALL come from the shared package cpu_types_pkg.
REQ-031 The FSM state enum and STARVE_MAX SHALL stay local to the module.
REQ-032 The block SHALL be a single module with no sub-modules: one sequential block plus combinational next-state and output logic.

Verification
REQ-033 iREN=1 only, iaddr=0x40, ramstate ACCESS on the 2nd grant cycle with ramload=0x1234 -> iwait=0 for one cycle, iload=0x1234, then IDLE.
REQ-034 iREN=dREN=1 together, STARVE_MAX=2, dcache re-requesting continuously -> grant order D, D, I.
REQ-035 dREN=dWEN=1, daddr=0x80, dstore=0xDEAD -> ramWEN=1, ramREN=0, ramstore=0xDEAD, dwait low on ACCESS.
REQ-036 DGRANT with ramstate=ERROR for 3 cycles, then ACCESS -> dwait=1 throughout the error, ramerr=1 and sticky until RST.
REQ-037 dREN dropped while ramstate=BUSY -> IDLE next edge, RAM strobes 0, no dload pulse.
REQ-038 RST pulsed in IGRANT -> immediate IDLE, ramREN=0, starve_cnt=0, ramerr=0.
